// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// Bundles the two requester ports, the tagged read-response channel and the
// single-port RAM connection of ram_port_arbiter into one interface.
//
// Signal summary:
//   req0/we0/addr0/wdata0 -> ack0 : requester port 0 (req held until ack)
//   req1/we1/addr1/wdata1 -> ack1 : requester port 1
//   rsp_valid/rsp_id/rsp_data     : read data returned with its owner id
//   ram_we/ram_addr/ram_din       : arbiter -> RAM
//   ram_dout                      : RAM -> arbiter (registered, 1-cycle latency)
//   busy                          : arbiter is in the middle of a transaction
//
// Modports:
//   master : the requester / RAM side (testbench or surrounding logic)
//   slave  : the arbiter itself
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  ack0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack1;

    logic                  rsp_valid;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    logic                  busy;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_dout,
        input  ack0, ack1,
        input  rsp_valid, rsp_id, rsp_data,
        input  ram_we, ram_addr, ram_din,
        input  busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_dout,
        output ack0, ack1,
        output rsp_valid, rsp_id, rsp_data,
        output ram_we, ram_addr, ram_din,
        output busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-requester arbiter and sequencer in front of a single-port RAM with a
// registered read port. One transaction is in flight at a time:
//   write : IDLE -> WR -> IDLE            (ack in WR, RAM writes at end of WR)
//   read  : IDLE -> RD -> RSP -> IDLE     (ack in RD, response in RSP)
// When both ports request in IDLE the port that did not win last time is
// chosen (round-robin); port 0 wins the first contended grant after reset.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_port_arbiter_if.slave (requester ports, response, RAM side)
//
// Configuration macro:
//   RAM_ARB_FIXED_PRIO_EN : when defined, port 0 always wins a contended
//                           grant; the last-grant register is still kept.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input logic               clk,
    input logic               rst_n,
    ram_port_arbiter_if.slave bus
);

    // The arbiter passes addresses through untouched, so the RAM must cover
    // the whole address space.
    if (DEPTH != (1 << ADDR_WIDTH)) begin : gDepthCheck
        $error("ram_port_arbiter: DEPTH must equal 2**ADDR_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  gnt_id_q, gnt_id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  winner;
    logic                  winner_we;

    // Pick the port to serve if a grant is made this cycle. Only meaningful
    // while at least one request is present.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_gnt_q;
`endif
        end else if (bus.req1) begin
            winner = 1'b1;
        end
        winner_we = winner ? bus.we1 : bus.we0;
    end

    // Next-state logic: requests are only looked at in IDLE, where the
    // winner's address/data are captured for the following WR or RD cycle.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_id_d   = gnt_id_q;
        addr_d     = addr_q;
        din_d      = din_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_id_d   = winner;
                    last_gnt_d = winner;
                    addr_d     = winner ? bus.addr1  : bus.addr0;
                    din_d      = winner ? bus.wdata1 : bus.wdata0;
                    state_d    = winner_we ? WR : RD;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register. last_gnt resets to 1 so that port 0 wins the first
    // contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_id_q   <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_id_q   <= gnt_id_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    // Strobes are decoded from the state register so that an asynchronous
    // reset clears them at once. The response fields are gated with RSP so
    // nothing stale leaks out between reads.
    assign bus.ram_we    = (state_q == WR);
    assign bus.ram_addr  = addr_q;
    assign bus.ram_din   = din_q;
    assign bus.ack0      = ((state_q == WR) || (state_q == RD)) && !gnt_id_q;
    assign bus.ack1      = ((state_q == WR) || (state_q == RD)) &&  gnt_id_q;
    assign bus.rsp_valid = (state_q == RSP);
    assign bus.rsp_id    = (state_q == RSP) && gnt_id_q;
    assign bus.rsp_data  = (state_q == RSP) ? bus.ram_dout : '0;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter. Holds a behavioural single-port
// RAM, a per-port request driver fed from queues, and a transaction-level
// reference model that schedules the expected outputs of every cycle.
// Honours RAM_ARB_FIXED_PRIO_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } portReq_t;

    typedef struct {
        logic          busy;
        logic          ack0;
        logic          ack1;
        logic          ramWe;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          rspValid;
        logic          rspId;
        logic [DW-1:0] rspData;
    } expect_t;

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expData;
    } vector_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    bit   randomMode = 1'b0;

    logic          drvReq   [2];
    logic          drvWe    [2];
    logic [AW-1:0] drvAddr  [2];
    logic [DW-1:0] drvWdata [2];
    portReq_t      reqQ [2][$];

    logic [DW-1:0] ramMem   [DEPTH];
    logic [DW-1:0] ramDout;
    logic [DW-1:0] modelMem [DEPTH];

    expect_t expQ[$];
    expect_t cur;
    int      lastGnt = 1;

    int   grantLog[$];
    int   ackCycles[$];
    rsp_t rspLog[$];

    vector_t vec[6];

    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    assign bus.req0     = drvReq[0];
    assign bus.we0      = drvWe[0];
    assign bus.addr0    = drvAddr[0];
    assign bus.wdata0   = drvWdata[0];
    assign bus.req1     = drvReq[1];
    assign bus.we1      = drvWe[1];
    assign bus.addr1    = drvAddr[1];
    assign bus.wdata1   = drvWdata[1];
    assign bus.ram_dout = ramDout;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Behavioural single-port RAM with a registered read port.
    always @(posedge clk) begin
        if (bus.ram_we) ramMem[bus.ram_addr] <= bus.ram_din;
        ramDout <= ramMem[bus.ram_addr];
    end

    function automatic expect_t idleExp();
        expect_t e;
        e = '{default: '0};
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Queue one request on a port; the driver issues it when the port is free.
    task automatic applyStimulus(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        portReq_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        reqQ[p].push_back(r);
    endtask

    // One driver step for a port: drop req once ack is seen, optionally make
    // up a random request, and issue the next queued request when free.
    task automatic stepPort(input int p);
        portReq_t r;
        logic     ackSeen;
        ackSeen = (p == 0) ? bus.ack0 : bus.ack1;
        if (!rst_n) begin
            drvReq[p] = 1'b0;
            reqQ[p].delete();
            return;
        end
        if (drvReq[p] && ackSeen) drvReq[p] = 1'b0;
        if (randomMode && reqQ[p].size() == 0 && $urandom_range(0, 3) != 0) begin
            r.we    = 1'($urandom_range(0, 1));
            r.addr  = AW'($urandom_range(0, DEPTH - 1));
            r.wdata = DW'($urandom_range(0, 255));
            reqQ[p].push_back(r);
        end
        if (!drvReq[p] && reqQ[p].size() > 0) begin
            r           = reqQ[p].pop_front();
            drvReq[p]   = 1'b1;
            drvWe[p]    = r.we;
            drvAddr[p]  = r.addr;
            drvWdata[p] = r.wdata;
        end
    endtask

    // Requester driver: acts 2 ns after each rising edge, once ack is settled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            stepPort(0);
            stepPort(1);
        end
    end

    // Reference model. At each edge that finds the arbiter idle with a request
    // pending, it picks a winner by the arbitration rule and schedules the
    // cycles that transaction will occupy: one ack cycle for a write, an ack
    // cycle then a response cycle for a read. Memory is updated at grant time
    // because transactions are strictly serialized.
    always @(posedge clk) begin
        cycle++;
        if (rst_n) begin
            if (!cur.busy && (drvReq[0] || drvReq[1])) begin
                int      w;
                expect_t e;
                if (drvReq[0] && drvReq[1]) w = FixedPrio ? 0 : 1 - lastGnt;
                else                        w = drvReq[1] ? 1 : 0;
                lastGnt = w;
                e       = idleExp();
                e.busy  = 1'b1;
                e.ack0  = (w == 0);
                e.ack1  = (w == 1);
                e.addr  = drvAddr[w];
                if (drvWe[w]) begin
                    e.ramWe = 1'b1;
                    e.din   = drvWdata[w];
                    modelMem[drvAddr[w]] = drvWdata[w];
                    expQ.push_back(e);
                end else begin
                    expQ.push_back(e);
                    e          = idleExp();
                    e.busy     = 1'b1;
                    e.rspValid = 1'b1;
                    e.rspId    = (w == 1);
                    e.rspData  = modelMem[drvAddr[w]];
                    expQ.push_back(e);
                end
            end
            cur = (expQ.size() > 0) ? expQ.pop_front() : idleExp();
        end
    end

    // Asynchronous reset drops everything the model had scheduled.
    always @(negedge rst_n) begin
        expQ.delete();
        cur     = idleExp();
        lastGnt = 1;
    end

    // Mid-cycle checker and monitor: compare against the model's current
    // expectation and log grants/responses for the directed sequences.
    always @(negedge clk) begin
        checkOutput("busy", bus.busy, cur.busy);
        checkOutput("ack0", bus.ack0, cur.ack0);
        checkOutput("ack1", bus.ack1, cur.ack1);
        checkOutput("ramWe", bus.ram_we, cur.ramWe);
        checkOutput("rspValid", bus.rsp_valid, cur.rspValid);
        if (cur.ack0 || cur.ack1) checkOutput("ramAddr", bus.ram_addr, cur.addr);
        if (cur.ramWe)            checkOutput("ramDin", bus.ram_din, cur.din);
        if (cur.rspValid) begin
            checkOutput("rspId", bus.rsp_id, cur.rspId);
            checkOutput("rspData", bus.rsp_data, cur.rspData);
        end
        if (bus.ack0) begin grantLog.push_back(0); ackCycles.push_back(cycle); end
        if (bus.ack1) begin grantLog.push_back(1); ackCycles.push_back(cycle); end
        if (bus.rsp_valid) rspLog.push_back('{int'(bus.rsp_id), bus.rsp_data});
    end

    task automatic clearLogs();
        grantLog.delete();
        ackCycles.delete();
        rspLog.delete();
    endtask

    // Wait until both ports have nothing left to issue and the arbiter is idle.
    task automatic waitDrain(input string name, input int maxCycles);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < maxCycles) begin
            @(posedge clk);
            #3;
            n++;
            done = (reqQ[0].size() == 0) && (reqQ[1].size() == 0) &&
                   !drvReq[0] && !drvReq[1] && !bus.busy;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        bit found;
        for (int i = 0; i < DEPTH; i++) begin
            ramMem[i]   = '0;
            modelMem[i] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            drvReq[p] = 1'b0; drvWe[p] = 1'b0; drvAddr[p] = '0; drvWdata[p] = '0;
        end
        ramDout = '0;
        cur     = idleExp();

        vec[0] = '{0, 1'b1, 4'd1, 8'hA5, 8'h00};
        vec[1] = '{0, 1'b0, 4'd1, 8'h00, 8'hA5};
        vec[2] = '{1, 1'b1, 4'd7, 8'h3C, 8'h00};
        vec[3] = '{1, 1'b0, 4'd7, 8'h00, 8'h3C};
        vec[4] = '{0, 1'b1, 4'd1, 8'hFF, 8'h00};
        vec[5] = '{1, 1'b0, 4'd1, 8'h00, 8'hFF};

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstAck0", bus.ack0, 0);
        checkOutput("rstAck1", bus.ack1, 0);
        checkOutput("rstRspValid", bus.rsp_valid, 0);
        checkOutput("rstRspId", bus.rsp_id, 0);
        checkOutput("rstRspData", bus.rsp_data, 0);
        checkOutput("rstRamWe", bus.ram_we, 0);
        checkOutput("rstRamAddr", bus.ram_addr, 0);
        checkOutput("rstRamDin", bus.ram_din, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single-port vectors, including a cross-port read-after-write.
        for (int i = 0; i < 6; i++) begin
            clearLogs();
            applyStimulus(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata);
            waitDrain("vecDrain", 20);
            checkOutput("vecGrantCount", grantLog.size(), 1);
            if (grantLog.size() > 0) checkOutput("vecGrantPort", grantLog[0], vec[i].port);
            if (!vec[i].we) begin
                checkOutput("vecRspCount", rspLog.size(), 1);
                if (rspLog.size() > 0) begin
                    checkOutput("vecRspId", rspLog[0].id, vec[i].port);
                    checkOutput("vecRspData", rspLog[0].data, vec[i].expData);
                end
            end
        end

        // Contention right after reset: port 0 first, then port 1.
        pulseReset();
        clearLogs();
        applyStimulus(0, 1'b1, 4'd2, 8'h5A);
        applyStimulus(1, 1'b1, 4'd3, 8'hC3);
        waitDrain("contWrDrain", 20);
        checkOutput("contWrGrants", grantLog.size(), 2);
        if (grantLog.size() == 2) begin
            checkOutput("contWrFirst", grantLog[0], 0);
            checkOutput("contWrSecond", grantLog[1], 1);
        end
        clearLogs();
        applyStimulus(0, 1'b0, 4'd2, 8'h00);
        applyStimulus(1, 1'b0, 4'd3, 8'h00);
        waitDrain("contRdDrain", 20);
        checkOutput("contRdRsps", rspLog.size(), 2);
        if (rspLog.size() == 2) begin
            checkOutput("contRdId0", rspLog[0].id, 0);
            checkOutput("contRdData0", rspLog[0].data, 8'h5A);
            checkOutput("contRdId1", rspLog[1].id, 1);
            checkOutput("contRdData1", rspLog[1].data, 8'hC3);
        end

        // Back-to-back reads on port 0 with req renewed immediately.
        applyStimulus(0, 1'b1, 4'd1, 8'h11);
        applyStimulus(0, 1'b1, 4'd2, 8'h22);
        applyStimulus(0, 1'b1, 4'd3, 8'h33);
        waitDrain("b2bWrDrain", 20);
        clearLogs();
        applyStimulus(0, 1'b0, 4'd1, 8'h00);
        applyStimulus(0, 1'b0, 4'd2, 8'h00);
        applyStimulus(0, 1'b0, 4'd3, 8'h00);
        waitDrain("b2bRdDrain", 30);
        checkOutput("b2bRsps", rspLog.size(), 3);
        if (rspLog.size() == 3) begin
            checkOutput("b2bData0", rspLog[0].data, 8'h11);
            checkOutput("b2bData1", rspLog[1].data, 8'h22);
            checkOutput("b2bData2", rspLog[2].data, 8'h33);
            checkOutput("b2bId2", rspLog[2].id, 0);
        end
        if (ackCycles.size() == 3) begin
            checkOutput("b2bGap0", ackCycles[1] - ackCycles[0], 3);
            checkOutput("b2bGap1", ackCycles[2] - ackCycles[1], 3);
        end

        // Both ports writing continuously: alternating grants (or port 0
        // first throughout with fixed priority).
        pulseReset();
        clearLogs();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b1, AW'(k + 8),  DW'(8'h40 + k));
            applyStimulus(1, 1'b1, AW'(k + 12), DW'(8'h80 + k));
        end
        waitDrain("contDrain", 60);
        checkOutput("contGrants", grantLog.size(), 8);
        if (grantLog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput("contGrantOrder", grantLog[i], FixedPrio ? (i < 4 ? 0 : 1) : (i % 2));
            end
            for (int i = 1; i < 8; i++) begin
                checkOutput("contWrGap", ackCycles[i] - ackCycles[i-1], 2);
            end
        end

        // Reset in the middle of a read.
        clearLogs();
        applyStimulus(0, 1'b0, 4'd7, 8'h00);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk);
            #1;
            if (bus.ack0) found = 1'b1;
        end
        checkOutput("rdAckSeen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstAck0", bus.ack0, 0);
        checkOutput("midRstRspValid", bus.rsp_valid, 0);
        checkOutput("midRstRamWe", bus.ram_we, 0);
        checkOutput("midRstBusy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        checkOutput("noRspAfterReset", rspLog.size(), 0);
        clearLogs();
        applyStimulus(1, 1'b0, 4'd7, 8'h00);
        waitDrain("postRstDrain", 20);
        checkOutput("postRstRsps", rspLog.size(), 1);
        if (rspLog.size() == 1) begin
            checkOutput("postRstId", rspLog[0].id, 1);
            checkOutput("postRstData", rspLog[0].data, 8'h3C);
        end

        // Ten quiet cycles.
        clearLogs();
        repeat (10) begin
            @(posedge clk);
            #1;
            checkOutput("idleBusy", bus.busy, 0);
            checkOutput("idleRamWe", bus.ram_we, 0);
        end
        checkOutput("idleGrants", grantLog.size(), 0);
        checkOutput("idleRsps", rspLog.size(), 0);

        // Randomized traffic on both ports against the reference model.
        randomMode = 1'b1;
        repeat (1500) @(posedge clk);
        #3 randomMode = 1'b0;
        waitDrain("randDrain", 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port RAM (ADDR_WIDTH/DATA_WIDTH/DEPTH RAM, registered dout, 1-cycle read latency).
- Accepts independent read/write requests from two masters and grants one at a time, round-robin.
- Drives the RAM's we/addr/din and returns read data tagged with the requester ID.
- Instantiated alongside single_port_ram; RAM ports wire straight through.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- DEPTH, 16, RAM word count; informational, must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  port 0 request; held high until ack0 is sampled.
- we0  input  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  input  ADDR_WIDTH  port 0 address.
- wdata0  input  DATA_WIDTH  port 0 write data.
- ack0  output  1  port 0 grant/accept pulse, 1 cycle.
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1.
- rsp_valid  output  1  read data valid, 1 cycle.
- rsp_id  output  1  requester that owns rsp_data.
- rsp_data  output  DATA_WIDTH  read data.
- ram_we  output  1  to RAM we.
- ram_addr  output  ADDR_WIDTH  to RAM addr.
- ram_din  output  DATA_WIDTH  to RAM din.
- ram_dout  input  DATA_WIDTH  from RAM dout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-low: one clock, clk.
- Reset values: state=IDLE, last_gnt=1 (so port 0 wins first), all outputs 0.
- FSM states: IDLE, WR, RD, RSP.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise select a winner.
  - Register ram_addr/ram_din from the winner; ram_we=we_winner; record gnt_id; set last_gnt=winner.
  - Next state is WR if we_winner, else RD.
- WR:
  - ram_we=1; RAM writes at the end of this cycle.
  - ack[gnt_id]=1.
  - Next state IDLE; ram_we returns to 0.
- RD:
  - ram_we=0, addr held; RAM captures dout at the end of this cycle.
  - ack[gnt_id]=1.
  - Next state RSP.
- RSP:
  - rsp_valid=1, rsp_data=ram_dout (registered copy is acceptable if timing is preserved), rsp_id=gnt_id.
  - Next state IDLE.
- Latency, from the edge that samples req in IDLE:
  - Write: ack high 1 cycle later.
  - Read: ack 1 cycle later, rsp_valid 2 cycles later.
- Throughput:
  - Write: 1 per 2 cycles.
  - Read: 1 per 3 cycles.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the one not equal to last_gnt wins (round-robin).
- Handshake:
  - Requester must drop or renew req in the cycle after sampling ack.
  - req is ignored outside IDLE.
  - A req still high in IDLE after its ack is treated as a new request.
- ack0 and ack1 are never high together; ack and rsp_valid are never high for the same transaction in the same cycle.
- Address wrap: none; addresses are passed unmodified. Out-of-range is impossible when DEPTH=2**ADDR_WIDTH.
- Reset mid-operation:
  - ram_we, ack, rsp_valid go to 0 immediately.
  - An in-flight write may or may not complete.
  - An in-flight read response is dropped.
  - FSM restarts in IDLE.
- Simultaneous write and read requests to the same address: serialized by arbitration order. A read granted after a write returns the new data.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins when both request. last_gnt is still updated but unused.
- Undefined: round-robin as above.
- Handshake, latency, and FSM are identical in both cases.

Test Plan:
- Write, then read back, port 0 only:
  - req0, we0=1, addr0=1, wdata0=A5 -> ack0 one cycle later, ram_we pulse with addr 1, din A5.
  - Then req0 read addr 1 -> ack0, then rsp_valid=1, rsp_id=0, rsp_data=A5.
- Contention round-robin:
  - After reset, both write at once: port 0 addr 2 data 5A, port 1 addr 3 data C3 -> ack0 first, then ack1.
  - Repeat both reading addr 2/3 -> port 0 first (last_gnt=1), rsp 5A id0, then C3 id1.
- Back-to-back same port:
  - req0 held through 3 reads of addr 1,2,3 (after writing 11,22,33) -> acks every 3 cycles, rsp_data 11,22,33 in order, id 0.
- Both ports continuously requesting writes:
  - Grants alternate 0,1,0,1 over 8 transactions.
  - With RAM_ARB_FIXED_PRIO_EN: all grants go to port 0 while req0 stays high.
- Reset during RD:
  - Assert rst_n=0 mid-RD -> ack/rsp_valid/ram_we immediately 0, busy=0.
  - No rsp_valid after release.
  - Next request is served normally.
- Idle check:
  - No requests for 10 cycles -> busy=0, ram_we=0, no ack or rsp_valid pulses.
